// File: rtl/sequenciador_polinomio.sv
// Sweep sequencer for the polynomial evaluator: steps X over N points, drives the
// inicio/pronto handshake and offers each captured result on a valid/ready stream.
//
// state   | meaning
// OCIOSO  | idle, waiting for cmd_inicio
// DISPARA | ev_inicio pulse, timeout counter loaded
// ESPERA  | waiting for a rising edge of ev_pronto or timeout
// ENTREGA | result offered on the stream until accepted
// FIM     | sweep finished; concluido pulses on the following cycle
module sequenciador_polinomio #(
    parameter int W       = 16,
    parameter int NW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          cmd_inicio,
    input  logic          cmd_abortar,
    input  logic [W-1:0]  X0,
    input  logic [W-1:0]  passo,
    input  logic [NW-1:0] N,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [W-1:0]  C,
    output logic [W-1:0]  ev_X,
    output logic [W-1:0]  ev_A,
    output logic [W-1:0]  ev_B,
    output logic [W-1:0]  ev_C,
    output logic          ev_inicio,
    input  logic [W-1:0]  ev_Resultado,
    input  logic          ev_pronto,
    input  logic          ev_overflow,
    output logic          res_valido,
    input  logic          res_aceito,
    output logic [W-1:0]  res_dado,
    output logic          res_ovf,
    output logic [NW-1:0] res_indice,
    output logic          ocupado,
    output logic          concluido,
    output logic          erro_timeout,
    output logic [NW-1:0] ovf_cont
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_INI = TW'(TIMEOUT - 1);
    localparam logic [NW-1:0] UM = NW'(1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        DISPARA = 3'd1,
        ESPERA  = 3'd2,
        ENTREGA = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t state, next_state;

    logic [W-1:0]  passo_r;
    logic [NW-1:0] n_r;
    logic [NW-1:0] k;
    logic [TW-1:0] cnt;
    logic          pronto_q;

    logic borda;
    logic ultimo;
    logic aceita_cmd;
    logic cap_res;
    logic expira;
    logic avanca;

    assign borda  = ev_pronto & ~pronto_q;
    assign ultimo = (k == n_r - UM);

    always_comb begin
        next_state = state;
        aceita_cmd = 1'b0;
        cap_res    = 1'b0;
        expira     = 1'b0;
        avanca     = 1'b0;
        case (state)
            OCIOSO: begin
                if (cmd_inicio) begin
                    aceita_cmd = 1'b1;
                    next_state = (N == '0) ? FIM : DISPARA;
                end
            end
            DISPARA: next_state = ESPERA;
            ESPERA: begin
                // a pronto edge in the expiry cycle still counts as a result
                if (borda) begin
                    cap_res    = ~cmd_abortar;
                    next_state = ENTREGA;
                end else if (cnt == '0) begin
                    expira     = ~cmd_abortar;
                    next_state = OCIOSO;
                end
            end
            ENTREGA: begin
                if (res_aceito) begin
                    avanca     = ~cmd_abortar & ~ultimo;
                    next_state = ultimo ? FIM : DISPARA;
                end
            end
            FIM:     next_state = OCIOSO;
            default: next_state = OCIOSO;
        endcase
        if (cmd_abortar && state != OCIOSO) begin
            next_state = OCIOSO;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= OCIOSO;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            passo_r      <= '0;
            n_r          <= '0;
            k            <= '0;
            cnt          <= '0;
            pronto_q     <= 1'b0;
            ev_X         <= '0;
            ev_A         <= '0;
            ev_B         <= '0;
            ev_C         <= '0;
            res_dado     <= '0;
            res_ovf      <= 1'b0;
            res_indice   <= '0;
            erro_timeout <= 1'b0;
            ovf_cont     <= '0;
            concluido    <= 1'b0;
        end else begin
            pronto_q  <= ev_pronto;
            concluido <= (state == FIM) & ~cmd_abortar;
            if (aceita_cmd) begin
                passo_r      <= passo;
                n_r          <= N;
                ev_X         <= X0;
                ev_A         <= A;
                ev_B         <= B;
                ev_C         <= C;
                k            <= '0;
                ovf_cont     <= '0;
                erro_timeout <= 1'b0;
            end
            if (state == DISPARA) begin
                cnt <= CNT_INI;
            end else if (state == ESPERA && cnt != '0) begin
                cnt <= cnt - TW'(1);
            end
            if (cap_res) begin
                res_dado   <= ev_Resultado;
                res_ovf    <= ev_overflow;
                res_indice <= k;
                if (ev_overflow && ovf_cont != {NW{1'b1}}) begin
                    ovf_cont <= ovf_cont + UM;
                end
            end
            if (expira) begin
                erro_timeout <= 1'b1;
            end
            if (avanca) begin
                k    <= k + UM;
                ev_X <= ev_X + passo_r;
            end
        end
    end

    assign ev_inicio  = (state == DISPARA);
    assign res_valido = (state == ENTREGA);
    // busy spans the whole command, including the cycle carrying concluido
    assign ocupado    = (state != OCIOSO) | concluido;

endmodule

// File: tb/tb_sequenciador_polinomio.sv
// Bench for sequenciador_polinomio: behavioural evaluator with programmable latency,
// a table of directed sweeps and hand-written sequences for the handshake corners.
module tb_sequenciador_polinomio;

    localparam int W  = 16;
    localparam int NW = 8;

    logic          ck = 1'b0;
    logic          rst;
    logic          cmd_inicio, cmd_abortar;
    logic [W-1:0]  X0, passo, A, B, C;
    logic [NW-1:0] N;
    logic [W-1:0]  ev_X, ev_A, ev_B, ev_C;
    logic          ev_inicio;
    logic [W-1:0]  ev_Resultado = '0;
    logic          ev_pronto    = 1'b0;
    logic          ev_overflow  = 1'b0;
    logic          res_valido, res_aceito;
    logic [W-1:0]  res_dado;
    logic          res_ovf;
    logic [NW-1:0] res_indice;
    logic          ocupado, concluido, erro_timeout;
    logic [NW-1:0] ovf_cont;

    int n_checks = 0;
    int n_fail   = 0;

    sequenciador_polinomio #(.W(W), .NW(NW), .TIMEOUT(10)) dut (
        .ck(ck), .rst(rst), .cmd_inicio(cmd_inicio), .cmd_abortar(cmd_abortar),
        .X0(X0), .passo(passo), .N(N), .A(A), .B(B), .C(C),
        .ev_X(ev_X), .ev_A(ev_A), .ev_B(ev_B), .ev_C(ev_C), .ev_inicio(ev_inicio),
        .ev_Resultado(ev_Resultado), .ev_pronto(ev_pronto), .ev_overflow(ev_overflow),
        .res_valido(res_valido), .res_aceito(res_aceito), .res_dado(res_dado),
        .res_ovf(res_ovf), .res_indice(res_indice), .ocupado(ocupado),
        .concluido(concluido), .erro_timeout(erro_timeout), .ovf_cont(ovf_cont)
    );

    always #5 ck = ~ck;

    // Evaluator model: pronto rises lat_sel+1 cycles after the ev_inicio cycle.
    int          lat_sel = 5;
    int          lat_cnt = 0;
    bit          mudo    = 1'b0;
    logic [W-1:0] op_x = '0, op_a = '0, op_b = '0, op_c = '0;

    function automatic logic [63:0] poly(logic [W-1:0] a, logic [W-1:0] b,
                                         logic [W-1:0] c, logic [W-1:0] x);
        return 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
    endfunction

    always @(posedge ck) begin
        if (ev_inicio) begin
            ev_pronto <= 1'b0;
            lat_cnt   <= lat_sel;
            op_x <= ev_X; op_a <= ev_A; op_b <= ev_B; op_c <= ev_C;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1 && !mudo) begin
                ev_pronto    <= 1'b1;
                ev_Resultado <= W'(poly(op_a, op_b, op_c, op_x));
                ev_overflow  <= (poly(op_a, op_b, op_c, op_x) >> W) != 64'd0;
            end
        end
    end

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic start(input logic [W-1:0] x0, input logic [W-1:0] p, input logic [NW-1:0] n,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        X0 = x0; passo = p; N = n; A = a; B = b; C = c;
        cmd_inicio = 1'b1;
        tick();
        cmd_inicio = 1'b0;
    endtask

    task automatic wait_valido(input string nome);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (res_valido) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(nome, 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (!ocupado) break;
            tick();
        end
        check("drain_idle", 64'(ocupado), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0]       x0;
        logic [W-1:0]       p;
        logic [NW-1:0]      n;
        logic [W-1:0]       a, b, c;
        logic [2:0][W-1:0]  ex;
        logic [2:0][W-1:0]  er;
        logic [2:0]         eo;
        logic [NW-1:0]      eoc;
    } vec_t;

    vec_t tab[4];

    initial begin
        tab[0] = '{x0: 16'd2, p: 16'd1, n: 8'd3, a: 16'd1, b: 16'd0, c: 16'd1,
                   ex: {16'd4, 16'd3, 16'd2}, er: {16'd17, 16'd10, 16'd5},
                   eo: 3'b000, eoc: 8'd0};
        tab[1] = '{x0: 16'hFFFF, p: 16'd1, n: 8'd2, a: 16'd1, b: 16'd0, c: 16'd1,
                   ex: {16'h0000, 16'h0000, 16'hFFFF}, er: {16'h0000, 16'h0001, 16'h0002},
                   eo: 3'b001, eoc: 8'd1};
        tab[2] = '{x0: 16'd10, p: 16'hFFFE, n: 8'd3, a: 16'd0, b: 16'd3, c: 16'd7,
                   ex: {16'd6, 16'd8, 16'd10}, er: {16'd25, 16'd31, 16'd37},
                   eo: 3'b000, eoc: 8'd0};
        tab[3] = '{x0: 16'h0100, p: 16'h0100, n: 8'd3, a: 16'd1, b: 16'd0, c: 16'd0,
                   ex: {16'h0300, 16'h0200, 16'h0100}, er: {16'h0000, 16'h0000, 16'h0000},
                   eo: 3'b111, eoc: 8'd3};

        rst = 1'b0; cmd_inicio = 1'b0; cmd_abortar = 1'b0; res_aceito = 1'b1;
        X0 = '0; passo = '0; N = '0; A = '0; B = '0; C = '0;
        tick(); tick();
        check("rst_ev_inicio", 64'(ev_inicio), 64'd0);
        check("rst_res_valido", 64'(res_valido), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_concluido", 64'(concluido), 64'd0);
        check("rst_erro", 64'(erro_timeout), 64'd0);
        check("rst_ovf_cont", 64'(ovf_cont), 64'd0);
        check("rst_ev_X", 64'(ev_X), 64'd0);
        check("rst_res_dado", 64'(res_dado), 64'd0);
        rst = 1'b1;
        tick();

        // table of full sweeps with the stream always ready
        for (int i = 0; i < 4; i++) begin
            int  kr, ki;
            bit  fim;
            kr = 0; ki = 0; fim = 1'b0;
            start(tab[i].x0, tab[i].p, tab[i].n, tab[i].a, tab[i].b, tab[i].c);
            check("lat_inicio", 64'(ev_inicio), 64'd1);
            for (int cyc = 0; cyc < 300 && !fim; cyc++) begin
                if (ev_inicio) begin
                    if (ki < 3) check("ev_X", 64'(ev_X), 64'(tab[i].ex[ki]));
                    ki++;
                end
                if (res_valido && res_aceito) begin
                    if (kr < 3) begin
                        check("res_dado", 64'(res_dado), 64'(tab[i].er[kr]));
                        check("res_ovf", 64'(res_ovf), 64'(tab[i].eo[kr]));
                        check("res_indice", 64'(res_indice), 64'(kr));
                    end
                    kr++;
                end
                if (concluido) fim = 1'b1;
                tick();
            end
            check("concluido_seen", 64'(fim), 64'd1);
            check("n_results", 64'(kr), 64'(tab[i].n));
            check("n_inicio", 64'(ki), 64'(tab[i].n));
            check("ovf_cont", 64'(ovf_cont), 64'(tab[i].eoc));
            drain();
        end

        // N=0: no evaluator start, busy for two cycles, concluido on the second
        start(16'd5, 16'd1, 8'd0, 16'd1, 16'd1, 16'd1);
        check("n0_c1_ocupado", 64'(ocupado), 64'd1);
        check("n0_c1_concluido", 64'(concluido), 64'd0);
        check("n0_c1_inicio", 64'(ev_inicio), 64'd0);
        tick();
        check("n0_c2_ocupado", 64'(ocupado), 64'd1);
        check("n0_c2_concluido", 64'(concluido), 64'd1);
        check("n0_c2_inicio", 64'(ev_inicio), 64'd0);
        tick();
        check("n0_c3_ocupado", 64'(ocupado), 64'd0);
        check("n0_c3_concluido", 64'(concluido), 64'd0);

        // evaluator never answers: timeout 11 cycles after ev_inicio
        mudo = 1'b1;
        start(16'd3, 16'd1, 8'd1, 16'd1, 16'd0, 16'd0);
        check("to_inicio", 64'(ev_inicio), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("to_d10_erro", 64'(erro_timeout), 64'd0);
        check("to_d10_ocupado", 64'(ocupado), 64'd1);
        tick();
        check("to_d11_erro", 64'(erro_timeout), 64'd1);
        check("to_d11_ocupado", 64'(ocupado), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("to_no_concluido", 64'(concluido), 64'd0);
            tick();
        end
        mudo = 1'b0;

        // pronto edge in the same cycle as expiry: the result wins
        lat_sel = 9;
        start(16'd7, 16'd1, 8'd1, 16'd0, 16'd0, 16'h1234);
        check("edge_erro_cleared", 64'(erro_timeout), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("edge_d10_valido", 64'(res_valido), 64'd0);
        tick();
        check("edge_d11_valido", 64'(res_valido), 64'd1);
        check("edge_d11_dado", 64'(res_dado), 64'h1234);
        check("edge_d11_erro", 64'(erro_timeout), 64'd0);
        drain();

        // pronto one cycle too late: timeout
        lat_sel = 10;
        start(16'd7, 16'd1, 8'd1, 16'd0, 16'd0, 16'h1234);
        for (int i = 0; i < 11; i++) tick();
        check("late_erro", 64'(erro_timeout), 64'd1);
        check("late_valido", 64'(res_valido), 64'd0);
        lat_sel = 5;
        tick(); tick();

        // backpressure: payload held, no new start until accepted
        res_aceito = 1'b0;
        start(16'd2, 16'd1, 8'd2, 16'd1, 16'd0, 16'd1);
        wait_valido("bp_wait");
        for (int i = 0; i < 20; i++) begin
            check("bp_valido", 64'(res_valido), 64'd1);
            check("bp_dado", 64'(res_dado), 64'd5);
            check("bp_no_inicio", 64'(ev_inicio), 64'd0);
            tick();
        end
        res_aceito = 1'b1;
        tick();
        check("bp_inicio_next", 64'(ev_inicio), 64'd1);
        check("bp_ev_X", 64'(ev_X), 64'd3);
        drain();

        // abort in ESPERA of point 1; cmd_inicio while busy is ignored
        start(16'd1, 16'd1, 8'd4, 16'd1, 16'd0, 16'd0);
        X0 = 16'd100; N = 8'd1;
        cmd_inicio = 1'b1;
        tick();
        cmd_inicio = 1'b0;
        wait_valido("ab_wait");
        check("ab_dado0", 64'(res_dado), 64'd1);
        check("ab_indice0", 64'(res_indice), 64'd0);
        tick();
        check("ab_inicio1", 64'(ev_inicio), 64'd1);
        check("ab_ev_X1", 64'(ev_X), 64'd2);
        tick();
        cmd_abortar = 1'b1;
        tick();
        cmd_abortar = 1'b0;
        check("ab_ocupado", 64'(ocupado), 64'd0);
        check("ab_erro", 64'(erro_timeout), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("ab_quiet", 64'({res_valido, concluido, ev_inicio}), 64'd0);
            tick();
        end

        // asynchronous reset while a result is on offer
        res_aceito = 1'b0;
        start(16'd2, 16'd1, 8'd2, 16'd1, 16'd0, 16'd1);
        wait_valido("rst_wait");
        rst = 1'b0;
        #1;
        check("arst_valido", 64'(res_valido), 64'd0);
        check("arst_ocupado", 64'(ocupado), 64'd0);
        check("arst_dado", 64'(res_dado), 64'd0);
        check("arst_ev_X", 64'(ev_X), 64'd0);
        tick();
        rst = 1'b1;
        res_aceito = 1'b1;
        tick();
        check("arst_after", 64'({ocupado, ev_inicio}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
